imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a big-endian byte stream into 32-bit words and holds the core in reset until loaded.
// Optional trailing XOR checksum of the image enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    input  logic              reload_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    // state  | meaning
    // LOAD   | accepting image bytes into the assembly register
    // COMMIT | one-cycle write of the assembled word
    // CHECK  | accepting the 4-byte checksum (checksum build only)
    // DONE   | image complete, core released, waiting for reload
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_LOAD, S_COMMIT, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_COMMIT, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              state_q, state_d;
    logic [31:0]         asm_q, asm_d;
    logic [1:0]          idx_q, idx_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         xor_q, xor_d;
`endif

    logic                accept;
    logic [31:0]         word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready_o = ((state_q == S_LOAD) || (state_q == S_CHECK)) && !rst;
`else
    assign in_ready_o = (state_q == S_LOAD) && !rst;
`endif

    assign accept = in_valid_i && in_ready_o;

    // Assembly register is cleared between words, so unreceived low bytes read as zero.
    always_comb begin
        word_next = asm_q;
        case (idx_q)
            2'd0:    word_next = {in_data_i, 24'h0};
            2'd1:    word_next = {asm_q[31:24], in_data_i, 16'h0};
            2'd2:    word_next = {asm_q[31:16], in_data_i, 8'h0};
            default: word_next = {asm_q[31:8], in_data_i};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        last_d    = last_q;
        addr_d    = addr_q;
        words_d   = words_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    asm_d = word_next;
                    idx_d = idx_q + 2'd1;
                    if ((idx_q == 2'd3) || in_last_i) begin
                        last_d    = in_last_i;
                        state_d   = S_COMMIT;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_next;
                    end
                end
            end

            S_COMMIT: begin
                asm_d   = 32'h0;
                idx_d   = 2'd0;
                words_d = words_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ wr_data_q;
`endif
                // Saturate the address on the top word so an overflow never points back at 0.
                if (addr_q != ADDR_MAX) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
`endif
                end else if (addr_q == ADDR_MAX) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    asm_d = word_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        asm_d     = 32'h0;
                        idx_d     = 2'd0;
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        err_d     = (word_next != xor_q);
                    end
                end
            end
`endif

            S_DONE: begin
                if (reload_i) begin
                    state_d   = S_LOAD;
                    asm_d     = 32'h0;
                    idx_d     = 2'd0;
                    last_d    = 1'b0;
                    addr_d    = '0;
                    words_d   = '0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d     = 32'h0;
`endif
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            asm_q     <= 32'h0;
            idx_q     <= 2'd0;
            last_q    <= 1'b0;
            addr_q    <= '0;
            words_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'h0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= 32'h0;
`endif
        end else begin
            state_q   <= state_d;
            asm_q     <= asm_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven images plus hand-written corner sequences.
// Expected memory writes go through a scoreboard queue popped on every observed wr_en.
module tb_imem_loader;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              reload;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .in_ready_o     (in_ready),
        .reload_i       (reload),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .cpu_rst_o      (cpu_rst),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words_loaded)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] words;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gap_max = 0;
    logic wr_en_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            chk("cpu_rst_vs_done", cpu_rst, !done);
            if (wr_en) begin
                chk("wr_en_one_cycle", wr_en_prev, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", wr_addr, w.addr);
                    chk("wr_data", wr_data, w.data);
                end
            end
            wr_en_prev = wr_en;
        end
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_q.push_back(wr_t'{addr: ADDR_W'(a), data: d});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int c;
        repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        c = 0;
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) chk("send_timeout", 1, 0);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        rst = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input int exp_wl);
        int c;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("done", done, 1);
        chk("cpu_rst_done", cpu_rst, 0);
        chk("err", err, exp_err);
        chk("words_loaded", words_loaded, exp_wl);
        chk("in_ready_done", in_ready, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_cpu_rst", cpu_rst, 1);
        chk("reload_done", done, 0);
        chk("reload_err", err, 0);
        chk("reload_words", words_loaded, 0);
        chk("reload_in_ready", in_ready, 1);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    // in_last on the first checksum byte must be ignored.
    task automatic send_csum(input logic [31:0] x);
        send_byte(x[31:24], 1'b1);
        send_byte(x[23:16], 1'b0);
        send_byte(x[15:8], 1'b0);
        send_byte(x[7:0], 1'b0);
    endtask
`endif

    initial begin
        logic [31:0] x;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0; reload = 1'b0;
        fork
            monitor();
        join_none

        vecs[0] = '{8, 64'h123456789ABCDEF0, 2, 64'h12345678_9ABCDEF0};
        vecs[1] = '{2, 64'hAABB000000000000, 1, 64'hAABB0000_00000000};
        vecs[2] = '{1, 64'h5C00000000000000, 1, 64'h5C000000_00000000};
        vecs[3] = '{3, 64'h0102030000000000, 1, 64'h01020300_00000000};
        vecs[4] = '{5, 64'h1122334455000000, 2, 64'h11223344_55000000};
        vecs[5] = '{4, 64'hDEADBEEF00000000, 1, 64'hDEADBEEF_00000000};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            gap_max = (i % 2) ? 3 : 0;
            for (int k = 0; k < vecs[i].nw; k++)
                push_wr(k, vecs[i].words[63-32*k -: 32]);
            for (int j = 0; j < vecs[i].nb; j++)
                send_byte(vecs[i].bytes[63-8*j -: 8], j == vecs[i].nb - 1);
            x = vecs[i].words[63:32] ^ ((vecs[i].nw == 2) ? vecs[i].words[31:0] : 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_csum(x);
`endif
            wait_done(1'b0, vecs[i].nw);
        end

        // Write latency, in_ready low during COMMIT, reload ignored mid-load.
        do_reset();
        gap_max = 0;
        push_wr(0, 32'hCAFEF00D);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hF0, 0); send_byte(8'h0D, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_wr_en", wr_en, 1);
        chk("lat_in_ready", in_ready, 0);
        @(negedge clk);
        chk("lat_wr_en_off", wr_en, 0);
        chk("lat_in_ready_back", in_ready, 1);
        chk("lat_words", words_loaded, 1);
        push_wr(1, 32'h77880000);
        send_byte(8'h77, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_ignored_cpu_rst", cpu_rst, 1);
        send_byte(8'h88, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_csum(32'hCAFEF00D ^ 32'h77880000);
`endif
        wait_done(1'b0, 2);

        // Overflow: 16 bytes fill DEPTH=4 words, further bytes refused.
        do_reset();
        gap_max = 1;
        for (int w = 0; w < 4; w++)
            push_wr(w, {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)});
        for (int k = 0; k < 16; k++)
            send_byte(8'(k + 1), 1'b0);
        @(negedge clk);
        in_data = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ovf_in_ready", in_ready, 0);
        end
        chk("ovf_done", done, 1);
        chk("ovf_err", err, 1);
        chk("ovf_words", words_loaded, 4);
        chk("ovf_wr_addr", wr_addr, 3);
        chk("ovf_queue_empty", exp_q.size(), 0);
        in_valid = 1'b0;

        // Reload from DONE.
        do_reload();
        push_wr(0, 32'h00000001);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_csum(32'h00000001);
`endif
        wait_done(1'b0, 1);

        // Random in_valid gaps, reset mid word 1 discards the partial word.
        do_reset();
        gap_max = 3;
        push_wr(0, 32'hA1B2C3D4);
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
        send_byte(8'hE5, 0); send_byte(8'hF6, 0);
        do_reset();
        chk("hs_word0_written", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        push_wr(0, 32'h0F1E2D3C);
        push_wr(1, 32'h4B000000);
        send_byte(8'h0F, 0); send_byte(8'h1E, 0); send_byte(8'h2D, 0); send_byte(8'h3C, 0);
        send_byte(8'h4B, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_csum(32'h0F1E2D3C ^ 32'h4B000000);
`endif
        wait_done(1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        gap_max = 0;
        push_wr(0, 32'h12345678);
        push_wr(1, 32'h9ABCDEF0);
        for (int j = 0; j < 8; j++) send_byte(vecs[0].bytes[63-8*j -: 8], j == 7);
        send_csum(32'h88888888);
        wait_done(1'b0, 2);
        do_reload();
        push_wr(0, 32'h12345678);
        push_wr(1, 32'h9ABCDEF0);
        for (int j = 0; j < 8; j++) send_byte(vecs[0].bytes[63-8*j -: 8], j == 7);
        send_csum(32'h88888889);
        wait_done(1'b1, 2);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
